// File: rtl/burst_checker.sv
// burst_checker
//
// Receiving-end monitor for the N/M burst generator. Every clock it samples
// the generator's OUT, RUNNING and BIS_END lines, measures how long OUT stays
// high and then low within one burst, and issues a one-cycle verdict per burst
// together with the measured lengths and saturating pass/fail tallies.
//
// A well-formed burst looks like this:
//   - RUNNING rises while OUT is already high.
//   - OUT is high for N_LEN cycles, then low for M_LEN cycles, with RUNNING
//     held high the whole time.
//   - BIS_END pulses on the cycle after the last low cycle. RUNNING may drop
//     on that same cycle.
//
// Parameters:
//   N_LEN  expected OUT-high phase length in cycles
//   M_LEN  expected OUT-low phase length in cycles
//   W      width of the phase counters (2^W-1 must exceed N_LEN and M_LEN)
//   TW     width of the pass/fail tallies
//
// Ports:
//   clk        clock; every input is synchronous to it
//   Reset      asynchronous active-high reset
//   enable     0 = hold in WAIT and ignore bursts; outputs keep their values
//   run_i      generator RUNNING
//   out_i      generator OUT
//   bis_end_i  generator BIS_END (one-cycle end-of-burst pulse)
//   done       one-cycle pulse: verdict outputs below have just been updated
//   pass       verdict of the last burst (err_code == 0), held until next done
//   err_code   0 ok, 1 bad start, 2 length mismatch, 3 protocol violation
//   n_meas     measured high-phase length of the last judged burst
//   m_meas     measured low-phase length of the last judged burst
//   pass_cnt   number of bursts passed, saturating
//   fail_cnt   number of bursts failed, saturating

module burst_checker #(
    parameter int N_LEN = 6,
    parameter int M_LEN = 13,
    parameter int W     = 5,
    parameter int TW    = 8
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic          enable,
    input  logic          run_i,
    input  logic          out_i,
    input  logic          bis_end_i,
    output logic          done,
    output logic          pass,
    output logic [1:0]    err_code,
    output logic [W-1:0]  n_meas,
    output logic [W-1:0]  m_meas,
    output logic [TW-1:0] pass_cnt,
    output logic [TW-1:0] fail_cnt
);

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_PH_N = 2'd1,
        S_PH_M = 2'd2,
        S_SKIP = 2'd3
    } state_t;

    localparam logic [1:0] ERR_OK    = 2'd0;
    localparam logic [1:0] ERR_START = 2'd1;
    localparam logic [1:0] ERR_LEN   = 2'd2;
    localparam logic [1:0] ERR_PROTO = 2'd3;

    localparam logic [W-1:0] N_EXP = W'(N_LEN);
    localparam logic [W-1:0] M_EXP = W'(M_LEN);
    localparam logic [W-1:0] ONE_W = W'(1);

    // Phase counters stick at all-ones so an overlong phase can never wrap
    // around and alias to the expected length.
    function automatic logic [W-1:0] cnt_inc(input logic [W-1:0] c);
        cnt_inc = (c == {W{1'b1}}) ? c : c + ONE_W;
    endfunction

    function automatic logic [TW-1:0] tally_inc(input logic [TW-1:0] c);
        tally_inc = (c == {TW{1'b1}}) ? c : c + TW'(1);
    endfunction

    state_t         state;
    state_t         state_nx;
    logic           run_d;
    logic [W-1:0]   n_cnt;
    logic [W-1:0]   m_cnt;
    logic [W-1:0]   n_nx;
    logic [W-1:0]   m_nx;
    logic           verdict;
    logic [1:0]     verdict_err;
    logic           run_rise;

    assign run_rise = run_i & ~run_d;

    // State register
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state <= S_WAIT;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state, counter updates and verdict decision
    always_comb begin
        state_nx    = state;
        n_nx        = n_cnt;
        m_nx        = m_cnt;
        verdict     = 1'b0;
        verdict_err = ERR_OK;

        if (!enable) begin
            // Any burst in progress is abandoned silently.
            state_nx = S_WAIT;
        end else begin
            case (state)
                S_WAIT: begin
                    // bis_end_i is deliberately ignored here.
                    if (run_rise) begin
                        if (out_i) begin
                            state_nx = S_PH_N;
                            n_nx     = ONE_W;
                            m_nx     = '0;
                        end else begin
                            verdict     = 1'b1;
                            verdict_err = ERR_START;
                            state_nx    = S_SKIP;
                            n_nx        = '0;
                            m_nx        = '0;
                        end
                    end
                end

                S_PH_N: begin
                    if (!run_i || bis_end_i) begin
                        verdict     = 1'b1;
                        verdict_err = ERR_PROTO;
                        state_nx    = S_WAIT;
                    end else if (out_i) begin
                        n_nx = cnt_inc(n_cnt);
                    end else begin
                        state_nx = S_PH_M;
                        m_nx     = ONE_W;
                    end
                end

                S_PH_M: begin
                    // bis_end_i outranks every other event in this phase.
                    if (bis_end_i) begin
                        verdict     = 1'b1;
                        verdict_err = ((n_cnt == N_EXP) && (m_cnt == M_EXP)) ? ERR_OK : ERR_LEN;
                        state_nx    = S_WAIT;
                    end else if (!run_i) begin
                        verdict     = 1'b1;
                        verdict_err = ERR_PROTO;
                        state_nx    = S_WAIT;
                    end else if (out_i) begin
                        // Still running: park in SKIP so the rest of this
                        // broken burst is not judged a second time.
                        verdict     = 1'b1;
                        verdict_err = ERR_PROTO;
                        state_nx    = S_SKIP;
                    end else begin
                        m_nx = cnt_inc(m_cnt);
                    end
                end

                S_SKIP: begin
                    if (!run_i) begin
                        state_nx = S_WAIT;
                    end
                end

                default: begin
                    state_nx = S_WAIT;
                end
            endcase
        end
    end

    // Counters, edge detector, verdict outputs and tallies
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            run_d    <= 1'b0;
            n_cnt    <= '0;
            m_cnt    <= '0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_code <= ERR_OK;
            n_meas   <= '0;
            m_meas   <= '0;
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else begin
            // Tracked even while disabled so enabling mid-burst sees no edge.
            run_d <= run_i;
            n_cnt <= n_nx;
            m_cnt <= m_nx;
            done  <= verdict;
            if (verdict) begin
                pass     <= (verdict_err == ERR_OK);
                err_code <= verdict_err;
                n_meas   <= n_nx;
                m_meas   <= m_nx;
                if (verdict_err == ERR_OK) begin
                    pass_cnt <= tally_inc(pass_cnt);
                end else begin
                    fail_cnt <= tally_inc(fail_cnt);
                end
            end
        end
    end

endmodule

// File: tb/tb_burst_checker.sv
// Directed testbench for burst_checker. A default instance (TW=8) and a
// TW=2 instance share the same stimulus; the narrow one exercises tally
// saturation.

module tb_burst_checker;

    logic       clk = 1'b0;
    logic       Reset;
    logic       enable;
    logic       run_i;
    logic       out_i;
    logic       bis_end_i;

    logic       done;
    logic       pass;
    logic [1:0] err_code;
    logic [4:0] n_meas;
    logic [4:0] m_meas;
    logic [7:0] pass_cnt;
    logic [7:0] fail_cnt;

    logic       s_done;
    logic       s_pass;
    logic [1:0] s_err;
    logic [4:0] s_n;
    logic [4:0] s_m;
    logic [1:0] s_pc;
    logic [1:0] s_fc;

    int n_checks = 0;
    int n_ok     = 0;
    int done_seen   = 0;
    int s_done_seen = 0;
    int base;

    burst_checker #(.N_LEN(6), .M_LEN(13), .W(5), .TW(8)) dut (
        .clk(clk), .Reset(Reset), .enable(enable), .run_i(run_i),
        .out_i(out_i), .bis_end_i(bis_end_i), .done(done), .pass(pass),
        .err_code(err_code), .n_meas(n_meas), .m_meas(m_meas),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
    );

    burst_checker #(.N_LEN(6), .M_LEN(13), .W(5), .TW(2)) dut_sat (
        .clk(clk), .Reset(Reset), .enable(enable), .run_i(run_i),
        .out_i(out_i), .bis_end_i(bis_end_i), .done(s_done), .pass(s_pass),
        .err_code(s_err), .n_meas(s_n), .m_meas(s_m),
        .pass_cnt(s_pc), .fail_cnt(s_fc)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_seen++;
        if (s_done === 1'b1) s_done_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_ok++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Drive one cycle of generator outputs, then sample just after the edge.
    task automatic step(input logic r, input logic o, input logic b);
        run_i = r; out_i = o; bis_end_i = b;
        @(posedge clk);
        #1;
    endtask

    // High nh cycles, low nl cycles, then BIS_END with RUNNING falling.
    task automatic burst(input int nh, input int nl);
        for (int i = 0; i < nh; i++) step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < nl; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic check_verdict(input string tag, input logic p, input logic [1:0] e,
                                 input logic [4:0] n, input logic [4:0] m);
        check({tag, ".done"}, done, 1'b1);
        check({tag, ".pass"}, pass, p);
        check({tag, ".err"}, err_code, e);
        check({tag, ".n_meas"}, n_meas, n);
        check({tag, ".m_meas"}, m_meas, m);
    endtask

    initial begin
        Reset = 1'b1; enable = 1'b1;
        run_i = 1'b0; out_i = 1'b0; bis_end_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.done", done, 1'b0);
        check("rst.pass", pass, 1'b0);
        check("rst.err", err_code, 2'd0);
        check("rst.n_meas", n_meas, 5'd0);
        check("rst.m_meas", m_meas, 5'd0);
        check("rst.pass_cnt", pass_cnt, 8'd0);
        check("rst.fail_cnt", fail_cnt, 8'd0);
        Reset = 1'b0;
        step(1'b0, 1'b0, 1'b0);

        // Nominal burst
        base = done_seen;
        burst(6, 13);
        check_verdict("nom", 1'b1, 2'd0, 5'd6, 5'd13);
        check("nom.pass_cnt", pass_cnt, 8'd1);
        check("nom.fail_cnt", fail_cnt, 8'd0);
        step(1'b0, 1'b0, 1'b0);
        check("nom.done_low", done, 1'b0);
        check("nom.pulses", done_seen - base, 1);

        // Short low phase
        burst(6, 12);
        check_verdict("short", 1'b0, 2'd2, 5'd6, 5'd12);
        check("short.fail_cnt", fail_cnt, 8'd1);
        step(1'b0, 1'b0, 1'b0);

        // Long high phase
        burst(7, 13);
        check_verdict("longn", 1'b0, 2'd2, 5'd7, 5'd13);
        check("longn.fail_cnt", fail_cnt, 8'd2);
        step(1'b0, 1'b0, 1'b0);

        // RUNNING drops during the high phase
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check_verdict("drop_n", 1'b0, 2'd3, 5'd3, 5'd0);
        check("drop_n.fail_cnt", fail_cnt, 8'd3);
        step(1'b0, 1'b0, 1'b0);

        // Bad start, then follow-on activity must stay silent
        base = done_seen;
        step(1'b1, 1'b0, 1'b0);
        check("bad.done", done, 1'b1);
        check("bad.err", err_code, 2'd1);
        check("bad.pass", pass, 1'b0);
        check("bad.fail_cnt", fail_cnt, 8'd4);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("bad.pulses", done_seen - base, 1);
        burst(6, 13);
        check_verdict("bad.next", 1'b1, 2'd0, 5'd6, 5'd13);
        check("bad.next.pass_cnt", pass_cnt, 8'd2);
        step(1'b0, 1'b0, 1'b0);

        // Glitch on the 5th low cycle
        base = done_seen;
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check_verdict("glitch", 1'b0, 2'd3, 5'd6, 5'd4);
        check("glitch.fail_cnt", fail_cnt, 8'd5);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("glitch.pulses", done_seen - base, 1);
        burst(6, 13);
        check_verdict("glitch.next", 1'b1, 2'd0, 5'd6, 5'd13);
        check("glitch.next.pass_cnt", pass_cnt, 8'd3);
        step(1'b0, 1'b0, 1'b0);

        // Reset during the 3rd high cycle
        base = done_seen;
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        run_i = 1'b1; out_i = 1'b1; bis_end_i = 1'b0;
        #2;
        Reset = 1'b1;
        #1;
        check("rstmid.pass", pass, 1'b0);
        check("rstmid.n_meas", n_meas, 5'd0);
        check("rstmid.m_meas", m_meas, 5'd0);
        check("rstmid.pass_cnt", pass_cnt, 8'd0);
        check("rstmid.fail_cnt", fail_cnt, 8'd0);
        run_i = 1'b0; out_i = 1'b0;
        @(posedge clk);
        #1;
        Reset = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("rstmid.pulses", done_seen - base, 0);
        burst(6, 13);
        check_verdict("rstmid.next", 1'b1, 2'd0, 5'd6, 5'd13);
        check("rstmid.next.pass_cnt", pass_cnt, 8'd1);
        step(1'b0, 1'b0, 1'b0);

        // Disable mid-burst, re-enable while RUNNING is still high
        base = done_seen;
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        enable = 1'b0;
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        enable = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 13; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        check("enable.pulses", done_seen - base, 0);
        check("enable.pass_cnt", pass_cnt, 8'd1);
        burst(6, 13);
        check_verdict("enable.next", 1'b1, 2'd0, 5'd6, 5'd13);
        check("enable.next.pass_cnt", pass_cnt, 8'd2);
        step(1'b0, 1'b0, 1'b0);

        // Five back-to-back bursts; TW=2 instance saturates at 3
        Reset = 1'b1;
        @(posedge clk);
        #1;
        Reset = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        base = s_done_seen;
        for (int k = 0; k < 5; k++) burst(6, 13);
        step(1'b0, 1'b0, 1'b0);
        check("sat.pulses", s_done_seen - base, 5);
        check("sat.pass_cnt", s_pc, 2'd3);
        check("sat.fail_cnt", s_fc, 2'd0);
        check("sat.pass", s_pass, 1'b1);
        check("sat.err", s_err, 2'd0);
        check("sat.n_meas", s_n, 5'd6);
        check("sat.m_meas", s_m, 5'd13);
        check("b2b.pass_cnt", pass_cnt, 8'd5);

        $display("%0d/%0d checks passed", n_ok, n_checks);
        $finish;
    end

endmodule
